// File: rtl/rvc_asap_mem_dump.sv
// rvc_asap_mem_dump: on EBREAK, streams the whole data memory out over valid/ready.
// Optional RVC_DUMP_SKIP_ZERO_EN: zero words other than the last are not sent.
module rvc_asap_mem_dump #(
    parameter logic [31:0] D_MEM_OFFSET = 32'h1000,
    parameter int          D_MEM_MSB    = 11,
    parameter logic [31:0] HALT_OPCODE  = 32'h00100073
) (
    input  logic        i_clock,
    input  logic        i_rst_n,
    input  logic [31:0] i_instruction,
    output logic        o_mem_rd_en,
    output logic [31:0] o_mem_rd_addr,
    input  logic [31:0] i_mem_rd_data,
    output logic        o_dump_valid,
    input  logic        i_dump_ready,
    output logic [31:0] o_dump_addr,
    output logic [31:0] o_dump_data,
    output logic        o_dump_last,
    output logic        o_busy,
    output logic        o_dump_done
);
    localparam logic [31:0] LAST_ADDR = 32'(D_MEM_OFFSET + (32'd1 << (D_MEM_MSB + 1)) - 32'd4);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        r_mem_rd_en;
    logic        r_dump_valid;
    logic [31:0] r_dump_addr;
    logic [31:0] r_dump_data;
    logic        r_dump_last;
    logic        r_busy;
    logic        r_done;
    logic        w_last;

    assign w_last        = r_cnt == LAST_ADDR;
    assign o_mem_rd_en   = r_mem_rd_en;
    assign o_mem_rd_addr = r_cnt;
    assign o_dump_valid  = r_dump_valid;
    assign o_dump_addr   = r_dump_addr;
    assign o_dump_data   = r_dump_data;
    assign o_dump_last   = r_dump_last;
    assign o_busy        = r_busy;
    assign o_dump_done   = r_done;

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_mem_rd_en  <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_instruction == HALT_OPCODE) begin
                    r_state     <= READ;
                    r_cnt       <= D_MEM_OFFSET;
                    r_mem_rd_en <= 1'b1;
                    r_busy      <= 1'b1;
                end
                READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= CAPTURE;
                end
                CAPTURE:
`ifdef RVC_DUMP_SKIP_ZERO_EN
                    if (i_mem_rd_data == 32'h0 && !w_last) begin
                        r_cnt       <= r_cnt + 32'd4;
                        r_mem_rd_en <= 1'b1;
                        r_state     <= READ;
                    end else
`endif
                    begin
                        r_dump_data  <= i_mem_rd_data;
                        r_dump_addr  <= r_cnt;
                        r_dump_last  <= w_last;
                        r_dump_valid <= 1'b1;
                        r_state      <= SEND;
                    end
                SEND: if (i_dump_ready) begin
                    r_dump_valid <= 1'b0;
                    if (r_dump_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt       <= r_cnt + 32'd4;
                        r_mem_rd_en <= 1'b1;
                        r_state     <= READ;
                    end
                end
                DONE: r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rvc_asap_mem_dump.sv
// tb_rvc_asap_mem_dump: directed bench for rvc_asap_mem_dump with a behavioural D_MEM.
module tb_rvc_asap_mem_dump;
    localparam logic [31:0] HALT = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    logic        busy;
    logic        done;

    logic [31:0] mem [1024];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    int n_total = 0;
    int n_bad = 0;
    int last_cnt, last_idx, stab_err, rd_err, busy_cnt, done_lag, timed_out;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[11:2]];

    rvc_asap_mem_dump dut (
        .i_clock(clk), .i_rst_n(rst_n), .i_instruction(instr),
        .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr), .i_mem_rd_data(rd_data),
        .o_dump_valid(valid), .i_dump_ready(ready), .o_dump_addr(addr),
        .o_dump_data(data), .o_dump_last(last), .o_busy(busy), .o_dump_done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_last"}, 32'(last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic do_reset();
        int seen = 0;
        rst_n = 1'b0;
        instr = HALT;
        ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen += int'(rd_en);
        end
        check("rst_rd_en_seen", 32'(seen), 0);
        check_zero("rst");
        rst_n = 1'b1;
        instr = 32'h13;
    endtask

    // Triggers a dump and collects every handshake until done or budget runs out.
    task automatic run_dump(input int pct, input bit hold_halt, input int budget);
        bit pv = 0, pr = 0, pl = 0, prd = 0, hs_prev = 0, got_done = 0;
        logic [31:0] pa = '0, pd = '0;
        q_addr.delete();
        q_data.delete();
        last_cnt = 0; last_idx = -1; stab_err = 0; rd_err = 0;
        busy_cnt = 0; done_lag = -1; timed_out = 0;
        instr = HALT;
        @(posedge clk); #1;
        if (!hold_halt) instr = 32'h13;
        for (int c = 0; c < budget && !got_done; c++) begin
            if (pv && !pr && !(valid && addr == pa && data == pd && last == pl)) stab_err++;
            if (prd && rd_en) rd_err++;
            if (busy) busy_cnt++;
            if (done) begin
                done_lag = hs_prev ? 1 : 0;
                got_done = 1;
            end else begin
                hs_prev = 0;
                ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
                if (valid && ready) begin
                    q_addr.push_back(addr);
                    q_data.push_back(data);
                    if (last) begin
                        last_cnt++;
                        last_idx = q_addr.size() - 1;
                    end
                    hs_prev = 1;
                end
                pv = valid; pr = ready; pa = addr; pd = data; pl = last; prd = rd_en;
                @(posedge clk); #1;
            end
        end
        timed_out = got_done ? 0 : 1;
        ready = 1'b0;
    endtask

    task automatic check_full(input string tag, input bit timing);
        int errs = 0;
        foreach (q_addr[k]) if (q_addr[k] !== 32'h1000 + 32'(4 * k) || q_data[k] !== mem[k]) errs++;
        check({tag, "_timeout"}, 32'(timed_out), 0);
        check({tag, "_xfers"}, 32'(q_addr.size()), 1024);
        check({tag, "_seq_err"}, 32'(errs), 0);
        check({tag, "_last_cnt"}, 32'(last_cnt), 1);
        check({tag, "_last_idx"}, 32'(last_idx), 1023);
        check({tag, "_done_lag"}, 32'(done_lag), 1);
        check({tag, "_stable"}, 32'(stab_err), 0);
        check({tag, "_rd_pulse"}, 32'(rd_err), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
        if (timing) check({tag, "_busy_cycles"}, 32'(busy_cnt), 3072);
    endtask

    initial begin
        int bad_post, hs;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);
        rd_data = '0;
        do_reset();
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 0);

        run_dump(100, 0, 4000);
        check_full("full", 1);

        do_reset();
        run_dump(30, 1, 20000);
        check_full("bp", 0);
        bad_post = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || rd_en || valid || !done) bad_post++;
        end
        check("retrig_post", 32'(bad_post), 0);

        do_reset();
        instr = HALT;
        ready = 1'b1;
        @(posedge clk); #1;
        instr = 32'h13;
        hs = 0;
        for (int c = 0; c < 1000 && hs < 100; c++) begin
            if (valid) hs++;
            @(posedge clk); #1;
        end
        check("mid_hs", 32'(hs), 100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("mid");
        rst_n = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        check("mid_idle_busy", 32'(busy), 0);
        run_dump(100, 0, 4000);
        check("restart_addr", q_addr.size() > 0 ? q_addr[0] : 32'hFFFF_FFFF, 32'h1000);
        check("restart_xfers", 32'(q_addr.size()), 1024);

`ifdef RVC_DUMP_SKIP_ZERO_EN
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEAD_BEEF;
        do_reset();
        run_dump(100, 0, 4000);
        check("skip_xfers", 32'(q_addr.size()), 2);
        check("skip_a0", q_addr.size() > 0 ? q_addr[0] : 32'hFFFF_FFFF, 32'h1010);
        check("skip_d0", q_data.size() > 0 ? q_data[0] : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        check("skip_a1", q_addr.size() > 1 ? q_addr[1] : 32'hFFFF_FFFF, 32'h1FFC);
        check("skip_d1", q_data.size() > 1 ? q_data[1] : 32'hFFFF_FFFF, 32'h0);
        check("skip_last_idx", 32'(last_idx), 1);
        check("skip_done_lag", 32'(done_lag), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rvc_asap_mem_dump.md
# rvc_asap_mem_dump

Hardware data-memory dump engine for the rvc_asap core. It is the read-out counterpart of the backdoor memory load. When the core's fetched instruction is EBREAK, the engine reads the whole data memory word by word through a synchronous read port. It streams each word with its byte address over a valid/ready interface, so a snapshot can leave the chip (debug UART/JTAG bridge) instead of relying on simulator hierarchy access. It sits beside the core, sharing the D_MEM read port when the core is halted.

## Interface
Parameters:
- D_MEM_OFFSET, 'h1000, byte address of first data-memory word.
- D_MEM_MSB, 11, data memory size is 2**(D_MEM_MSB+1) bytes (default 4096 bytes = 1024 words).
- HALT_OPCODE, 32'h00100073, instruction value that triggers the dump (EBREAK).

Ports:
- Clock  in  1  single clock, all logic on rising edge.
- RstN  in  1  synchronous, active-low reset.
- Instruction  in  32  core's current instruction.
- MemRdEn  out  1  read strobe to D_MEM.
- MemRdAddr  out  32  byte address, word aligned.
- MemRdData  in  32  little-endian word {B[a+3],B[a+2],B[a+1],B[a]}, valid one cycle after MemRdEn.
- DumpValid  out  1  output word valid.
- DumpReady  in  1  sink accepts word.
- DumpAddr  out  32  byte address of DumpData.
- DumpData  out  32  memory word.
- DumpLast  out  1  qualifies the final word (address D_MEM_OFFSET+SIZE-4).
- Busy  out  1  dump in progress.
- DumpDone  out  1  level, dump complete.

## Operation
- FSM states: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: if Instruction==HALT_OPCODE, go READ with the address counter at D_MEM_OFFSET.
- READ: MemRdEn=1, MemRdAddr=counter; go CAPTURE.
- CAPTURE: register MemRdData into DumpData and the counter into DumpAddr; go SEND.
- SEND: DumpValid=1. DumpAddr, DumpData and DumpLast are held stable until DumpValid&&DumpReady at a rising edge.
  - On that transfer: if last, go DONE; else counter+=4 and go READ.
- DONE: DumpDone=1 and Busy=0 until reset. Only one dump happens per reset.
- Busy=1 in READ, CAPTURE and SEND.
- Counter width is 32 bits. The last address is D_MEM_OFFSET + 2**(D_MEM_MSB+1) - 4, and comparison is exact, so the counter never wraps.
- EBREAK seen while Busy or in DONE is ignored. Instruction changing after the trigger is ignored.
- DumpReady may toggle arbitrarily. DumpValid is never withdrawn before the transfer.
- Reset (RstN=0 at an edge) in any state returns to IDLE. All outputs then read 0: MemRdEn, MemRdAddr, DumpValid, DumpAddr, DumpData, DumpLast, Busy, DumpDone.

## Timing
- Trigger sampled at edge T (state IDLE).
- Edge T+1: state READ, so MemRdEn=1 in cycle T+1..T+2.
- MemRdData is valid in CAPTURE and registered at edge T+3.
- DumpValid=1 from edge T+3.
- Minimum 3 cycles per word with DumpReady held high, so 3*1024 cycles for the default size.
- After the final transfer at edge E: DumpDone=1 and Busy=0 from edge E+1.
- MemRdEn is a single-cycle pulse per word.

## Configuration
- RVC_DUMP_SKIP_ZERO_EN.
- Defined: in CAPTURE, a word equal to 32'h0 that is not the last word is not sent.
  - The FSM increments the counter and returns to READ, costing 2 cycles per skipped word.
  - The last word is always sent, even if zero, so DumpLast always appears exactly once.
- Undefined: every word is sent, always 2**(D_MEM_MSB+1)/4 transfers.

## Test plan
- Reset/idle: hold RstN=0 two cycles with Instruction=32'h00100073 -> all outputs 0, no MemRdEn.
- Full dump, DumpReady=1, memory word i = 32'hA5000000+i -> 1024 transfers.
  - DumpAddr 'h1000..'h1FFC, DumpData matching.
  - DumpLast only on 'h1FFC.
  - DumpDone high 1 cycle after the last transfer.
  - Total 3072 cycles from trigger edge.
- Back-pressure: DumpReady random 30% high -> data/address stable while Valid&&!Ready, same sequence of 1024 words, no drops/duplicates.
- Retrigger: EBREAK held high during and after the dump -> exactly one dump; DONE persists.
- Reset mid-dump at word 100 -> outputs 0 next cycle. A new EBREAK restarts at 'h1000.
- With RVC_DUMP_SKIP_ZERO_EN, memory all zero except 'h1010=32'hDEADBEEF -> exactly two transfers: 'h1010/DEADBEEF, then 'h1FFC/0 with DumpLast=1.
